fp_add_sub_arbiter: RTL

Shares one pipelined fp_add_sub unit (fixed latency, one op per cycle) between NUM_REQ shader-core requesters. Round-robin grant, registered operand issue to the FPU, and a tag shift pipeline that routes each result back to its requester. Sits between the per-core ALU issue logic and the single FPU instance; a global stall freezes the arbiter and the FPU together.

---
 rtl/fp_arb_pkg.sv | 23 ++
 rtl/fp_add_sub_arbiter_rr_pick.sv | 53 +++++
 rtl/fp_add_sub_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the fp_add_sub arbiter.
// Tag ids are carried at the width of the largest supported configuration
// (8 requesters), so one tag type serves every NUM_REQ from 1 to 8.
package fp_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int TAG_W   = (MAX_REQ > 1) ? $clog2(MAX_REQ) : 1;

  // FPU op-select encoding on fpu_add_sub
  localparam logic FPU_OP_ADD = 1'b1;
  localparam logic FPU_OP_SUB = 1'b0;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] id;
  } tag_t;

  // (a + b) mod n, used for pointer wrap and rotate index arithmetic
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/fp_add_sub_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so the pointer slot is
// bit 0, priority-encode the lowest set bit, rotate the winner index back.
module fp_arb_rr_pick
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [TAG_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [TAG_W-1:0]   grant_id_o,
  output logic               any_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] rot;
  logic               found;
  int                 first;
  int                 win;

  // Rotate requests so that the requester at ptr_i lands on bit 0
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req_i[IDX_W'(wrap_add(i, int'(ptr_i), NUM_REQ))];
    end
  end

  // Priority-encode the rotated vector, then map the winner back
  always_comb begin
    found = 1'b0;
    first = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        first = i;
      end
    end
    win = wrap_add(first, int'(ptr_i), NUM_REQ);
  end

  // One-hot grant and binary id for the winner
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_o[i] = found && (win == i);
    end
    grant_id_o = TAG_W'(win);
    any_o      = found;
  end

endmodule

// File: rtl/fp_add_sub_arbiter.sv
// Shares one pipelined fp_add_sub unit between NUM_REQ requesters.
// Round-robin grant, registered operand issue, and a tag shift pipeline that
// routes each result back to the requester that issued it.
// Optional build macro: FP_ARB_PERF_EN adds issue/contention counters.
//
// Handshake: an op transfers in a cycle where req_valid[i] & req_ready[i];
// req_ready is one-hot, never asserted under stall, during reset, or in the
// first cycle after reset. resp_valid is a one-cycle pulse with no
// backpressure; the requester must take it.
module fp_add_sub_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 7,
  parameter int WIDTH   = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic [WIDTH-1:0]         fpu_dataa,
  output logic [WIDTH-1:0]         fpu_datab,
  output logic                     fpu_add_sub,
  output logic                     fpu_clk_en,
  input  logic [WIDTH-1:0]         fpu_result,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_result
`ifdef FP_ARB_PERF_EN
  ,
  output logic [31:0]              perf_issue_cnt,
  output logic [31:0]              perf_contend_cnt
`endif
);

  logic [TAG_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]   dataa_q, dataa_d;
  logic [WIDTH-1:0]   datab_q, datab_d;
  logic               op_q, op_d;
  logic               rst_done_q;
  tag_t               tag_q [0:LATENCY];
  tag_t               tag_d [0:LATENCY];

  logic [NUM_REQ-1:0] pick_grant;
  logic [TAG_W-1:0]   pick_id;
  logic               pick_any;
  logic               issue_ok;
  logic               hs;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_sub;
  tag_t               last_tag;

  fp_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i      (req_valid),
    .ptr_i      (ptr_q),
    .grant_o    (pick_grant),
    .grant_id_o (pick_id),
    .any_o      (pick_any)
  );

  // Grant gating: nothing issues under stall, in reset, or the cycle after
  always_comb begin
    issue_ok  = reset_n && rst_done_q && !stall;
    req_ready = issue_ok ? pick_grant : '0;
    hs        = issue_ok && pick_any;
  end

  // Select the granted requester's operands
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_sub = req_sub[i];
      end
    end
  end

  // Next-state for pointer, operand registers and tag pipeline
  always_comb begin
    ptr_d   = ptr_q;
    dataa_d = dataa_q;
    datab_d = datab_q;
    op_d    = op_q;
    tag_d   = tag_q;
    if (hs) begin
      ptr_d   = TAG_W'(wrap_add(int'(pick_id), 1, NUM_REQ));
      dataa_d = sel_a;
      datab_d = sel_b;
      op_d    = sel_sub ? FPU_OP_SUB : FPU_OP_ADD;
    end
    if (!stall) begin
      tag_d[0].valid = hs;
      tag_d[0].id    = hs ? pick_id : '0;
      for (int k = 1; k <= LATENCY; k++) begin
        tag_d[k] = tag_q[k-1];
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      dataa_q    <= '0;
      datab_q    <= '0;
      op_q       <= FPU_OP_ADD;
      rst_done_q <= 1'b0;
      for (int k = 0; k <= LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      dataa_q    <= dataa_d;
      datab_q    <= datab_d;
      op_q       <= op_d;
      rst_done_q <= 1'b1;
      for (int k = 0; k <= LATENCY; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  // Result routing from the last tag stage; suppressed under stall/reset
  always_comb begin
    last_tag   = tag_q[LATENCY];
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = reset_n && !stall && last_tag.valid &&
                      (last_tag.id == TAG_W'(i));
    end
  end

  assign fpu_dataa   = dataa_q;
  assign fpu_datab   = datab_q;
  assign fpu_add_sub = op_q;
  assign fpu_clk_en  = ~stall;
  assign resp_result = fpu_result;

`ifdef FP_ARB_PERF_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] contend_cnt_q, contend_cnt_d;
  int          req_pop;

  // Counter next-state: issues and non-stalled cycles with 2+ requests
  always_comb begin
    req_pop = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_pop = req_pop + (req_valid[i] ? 1 : 0);
    end
    issue_cnt_d   = issue_cnt_q + (hs ? 32'd1 : 32'd0);
    contend_cnt_d = contend_cnt_q +
                    ((reset_n && !stall && (req_pop >= 2)) ? 32'd1 : 32'd0);
  end

  // Performance counter registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      issue_cnt_q   <= '0;
      contend_cnt_q <= '0;
    end else begin
      issue_cnt_q   <= issue_cnt_d;
      contend_cnt_q <= contend_cnt_d;
    end
  end

  assign perf_issue_cnt   = issue_cnt_q;
  assign perf_contend_cnt = contend_cnt_q;
`else
  // No performance counters in this build.
`endif

endmodule
